// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM port arbiter.
// Holds the FSM state encoding, the latched request record and the
// lowest-set-bit helper used by the grant picker.
package sdram_arb_pkg;

    // Upper bound on client count supported by the grant picker.
    localparam int MAX_PORTS = 8;
    localparam int PIDX_W    = 3;

    // Controller word-address width; the top's AW parameter must match it.
    localparam int SD_AW = 26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Snapshot of the granted client's request, frozen for the whole transaction.
    typedef struct packed {
        logic [SD_AW-1:0] addr;
        logic             we;
        logic             burst;
        logic [15:0]      wdata;
        logic [1:0]       wbs;
    } req_t;

    // Index of the lowest set bit of v; returns 0 when v is all zero.
    function automatic logic [PIDX_W-1:0] lowest_set(input logic [MAX_PORTS-1:0] v);
        logic [PIDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_PORTS - 1; i >= 0; i--) begin
            if (v[i]) idx = PIDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_grant.sv
// Combinational grant picker for the SDRAM port arbiter.
// Searches req starting just past last_grant (wrapping). When last_grant is
// held at NPORTS-1 the search always starts at port 0, which is plain
// fixed priority with the lowest index winning.
module sdram_arb_grant
    import sdram_arb_pkg::*;
#(
    parameter int NPORTS = 3,
    parameter int IW     = 2
) (
    input  logic [NPORTS-1:0] req,
    input  logic [IW-1:0]     last_grant,
    output logic [NPORTS-1:0] grant,
    output logic [IW-1:0]     grant_idx
);

    logic [IW-1:0]        start;
    logic [MAX_PORTS-1:0] rot;
    logic [PIDX_W-1:0]    lo;
    logic [PIDX_W:0]      sum;

    // Rotate req so the search origin sits at bit 0, pick the lowest set bit,
    // then rotate the index back into port numbering.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // branch; a path that leaves one unassigned infers a latch.
        start = (last_grant == IW'(NPORTS - 1)) ? '0 : last_grant + 1'b1;
        rot   = '0;
        for (int i = 0; i < NPORTS; i++) begin
            rot[i] = req[(i + int'(start)) % NPORTS];
        end
        lo  = lowest_set(rot);
        sum = {1'b0, lo} + (PIDX_W + 1)'(start);
        if (sum >= (PIDX_W + 1)'(NPORTS)) begin
            sum = sum - (PIDX_W + 1)'(NPORTS);
        end
        grant_idx = IW'(sum);
        for (int i = 0; i < NPORTS; i++) begin
            grant[i] = (|req) && (grant_idx == IW'(i));
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Multi-client arbiter in front of the SDRAM controller.
// Serialises word/burst reads and word writes from NPORTS clients, runs the
// controller's rd/wr + ready handshake, and returns a one-cycle ack (plus err
// on a ready timeout) with the 64-bit read result.
// Optional build macro SDRAM_ARB_ROUND_ROBIN_EN: rotating priority starting
// after the last winner. Undefined: fixed priority, port 0 highest.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NPORTS  = 3,
    parameter int TIMEOUT = 64,
    parameter int AW      = SD_AW
) (
    input  logic                 clk,
    input  logic                 init,
    input  logic [NPORTS-1:0]    req,
    input  logic [NPORTS-1:0]    we,
    input  logic [NPORTS-1:0]    burst,
    input  logic [NPORTS*AW-1:0] addr,
    input  logic [NPORTS*16-1:0] wdata,
    input  logic [NPORTS*2-1:0]  wbs,
    output logic [NPORTS-1:0]    ack,
    output logic                 err,
    output logic [63:0]          rdata,
    output logic                 sd_sel,
    output logic [AW-1:0]        sd_addr,
    output logic [15:0]          sd_din,
    output logic [1:0]           sd_bs,
    output logic                 sd_rd,
    output logic                 sd_wr,
    output logic                 sd_burst,
    input  logic                 sd_ready,
    input  logic [63:0]          sd_dout
);

    localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t            state, state_nxt;
    req_t              cur, cur_nxt;
    logic [NPORTS-1:0] gnt, gnt_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [NPORTS-1:0] ack_nxt;
    logic              err_nxt;
    logic [63:0]       rdata_nxt;
    logic              sel_nxt, rd_nxt, wr_nxt;

    logic [NPORTS-1:0] grant;
    logic [IW-1:0]     grant_idx;
    logic [IW-1:0]     last_grant;
    logic              take;

    // A grant is taken only in IDLE and never in the ack cycle of a timeout,
    // so the aborted client gets one cycle to drop or renew its request.
    assign take = (state == IDLE) && (|req) && !(|ack);

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    // Remember the most recent winner so the next search starts just past it.
    always_ff @(posedge clk) begin
        if (init) begin
            last_grant <= IW'(NPORTS - 1);
        end else if (take) begin
            last_grant <= grant_idx;
        end
    end
`else
    // Search origin pinned to port 0: the picker degenerates to fixed priority.
    assign last_grant = IW'(NPORTS - 1);
`endif

    sdram_arb_grant #(
        .NPORTS (NPORTS),
        .IW     (IW)
    ) u_grant (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // Controller address/data/strobes come straight from the frozen request.
    assign sd_addr  = cur.addr;
    assign sd_din   = cur.wdata;
    assign sd_bs    = cur.wbs;
    assign sd_burst = cur.burst;

    // Next-state and next-output logic for the IDLE/ISSUE/BUSY/DONE handshake.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        gnt_nxt   = gnt;
        cnt_nxt   = cnt;
        ack_nxt   = '0;
        err_nxt   = 1'b0;
        rdata_nxt = rdata;
        sel_nxt   = sd_sel;
        rd_nxt    = sd_rd;
        wr_nxt    = sd_wr;

        unique case (state)
            IDLE: begin
                if (take) begin
                    gnt_nxt       = grant;
                    cur_nxt.addr  = addr[grant_idx*AW +: AW];
                    cur_nxt.we    = we[grant_idx];
                    cur_nxt.burst = burst[grant_idx] & ~we[grant_idx];
                    cur_nxt.wdata = wdata[grant_idx*16 +: 16];
                    cur_nxt.wbs   = wbs[grant_idx*2 +: 2];
                    sel_nxt       = 1'b1;
                    rd_nxt        = ~we[grant_idx];
                    wr_nxt        = we[grant_idx];
                    cnt_nxt       = '0;
                    state_nxt     = ISSUE;
                end
            end

            ISSUE: begin
                // Ready already high on entry is the idle level, not completion;
                // only its fall acknowledges the command.
                if (!sd_ready) begin
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    state_nxt = BUSY;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    sel_nxt   = 1'b0;
                    ack_nxt   = gnt;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            BUSY: begin
                if (sd_ready) begin
                    if (!cur.we) rdata_nxt = sd_dout;
                    ack_nxt   = gnt;
                    sel_nxt   = 1'b0;
                    state_nxt = DONE;
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; init clears everything including rdata.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register
        // samples pre-edge values regardless of statement order.
        if (init) begin
            state  <= IDLE;
            cur    <= '0;
            gnt    <= '0;
            cnt    <= '0;
            ack    <= '0;
            err    <= 1'b0;
            rdata  <= '0;
            sd_sel <= 1'b0;
            sd_rd  <= 1'b0;
            sd_wr  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cur    <= cur_nxt;
            gnt    <= gnt_nxt;
            cnt    <= cnt_nxt;
            ack    <= ack_nxt;
            err    <= err_nxt;
            rdata  <= rdata_nxt;
            sd_sel <= sel_nxt;
            sd_rd  <= rd_nxt;
            sd_wr  <= wr_nxt;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter with a small SDRAM
// controller model: ready falls one cycle after rd/wr, stays low six cycles,
// then rises with sd_dout; a "stuck" mode keeps ready high forever.
module tb_sdram_port_arbiter;

    localparam int NPORTS     = 3;
    localparam int TIMEOUT    = 64;
    localparam int AW         = 26;
    localparam int LOW_CYCLES = 6;
    localparam int READ_LAT   = 8;   // issue cycle -> ack cycle with the model above

    logic                 clk = 1'b0;
    logic                 init;
    logic [NPORTS-1:0]    req, we, burst, ack;
    logic [NPORTS*AW-1:0] addr;
    logic [NPORTS*16-1:0] wdata;
    logic [NPORTS*2-1:0]  wbs;
    logic                 err;
    logic [63:0]          rdata, sd_dout;
    logic                 sd_sel, sd_rd, sd_wr, sd_burst, sd_ready;
    logic [AW-1:0]        sd_addr;
    logic [15:0]          sd_din;
    logic [1:0]           sd_bs;

    int   n_checks = 0;
    int   n_errors = 0;
    logic stuck;
    logic m_busy;
    int   m_cnt;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .NPORTS  (NPORTS),
        .TIMEOUT (TIMEOUT),
        .AW      (AW)
    ) dut (
        .clk      (clk),
        .init     (init),
        .req      (req),
        .we       (we),
        .burst    (burst),
        .addr     (addr),
        .wdata    (wdata),
        .wbs      (wbs),
        .ack      (ack),
        .err      (err),
        .rdata    (rdata),
        .sd_sel   (sd_sel),
        .sd_addr  (sd_addr),
        .sd_din   (sd_din),
        .sd_bs    (sd_bs),
        .sd_rd    (sd_rd),
        .sd_wr    (sd_wr),
        .sd_burst (sd_burst),
        .sd_ready (sd_ready),
        .sd_dout  (sd_dout)
    );

    // Controller model.
    always @(posedge clk) begin
        if (init) begin
            sd_ready <= 1'b1;
            m_busy   <= 1'b0;
            m_cnt    <= 0;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                sd_ready <= 1'b1;
                m_busy   <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (!stuck && (sd_rd || sd_wr)) begin
            sd_ready <= 1'b0;
            m_busy   <= 1'b1;
            m_cnt    <= LOW_CYCLES - 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Count negedges until ack shows up, giving up after limit cycles.
    task automatic wait_ack(input int limit, output int cyc);
        cyc = 0;
        while (ack == '0 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic set_port(input int p, input logic w, input logic b,
                            input logic [AW-1:0] a, input logic [15:0] d,
                            input logic [1:0] s);
        we[p]              = w;
        burst[p]           = b;
        addr[p*AW +: AW]   = a;
        wdata[p*16 +: 16]  = d;
        wbs[p*2 +: 2]      = s;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int ack_seen;
        int gi;
        int last_g;
        logic [NPORTS-1:0] exp_g;

        init = 1'b1; req = '0; we = '0; burst = '0; addr = '0;
        wdata = '0; wbs = '0; sd_dout = '0; stuck = 1'b0;
        last_g = NPORTS - 1;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_ack",    ack,      0);
        check("rst_err",    err,      0);
        check("rst_rdata",  rdata,    0);
        check("rst_sel",    sd_sel,   0);
        check("rst_rd",     sd_rd,    0);
        check("rst_wr",     sd_wr,    0);
        check("rst_burst",  sd_burst, 0);
        check("rst_addr",   sd_addr,  0);
        check("rst_din",    sd_din,   0);
        check("rst_bs",     sd_bs,    0);
        init = 1'b0;
        @(negedge clk);

        // ---- single read, port 1; addr changes while granted are ignored ----
        set_port(1, 1'b0, 1'b0, 26'h000100, 16'h0, 2'b00);
        sd_dout = 64'h0000_0000_0000_ABCD;
        req = 3'b010;
        @(negedge clk);
        check("rd_sel",   sd_sel,   1);
        check("rd_rd",    sd_rd,    1);
        check("rd_wr",    sd_wr,    0);
        check("rd_addr",  sd_addr,  26'h000100);
        check("rd_burst", sd_burst, 0);
        set_port(1, 1'b0, 1'b0, 26'h000200, 16'h0, 2'b00);
        wait_ack(40, cyc);
        check("rd_latency",  cyc,          READ_LAT);
        check("rd_ack",      ack,          3'b010);
        check("rd_err",      err,          0);
        check("rd_data",     rdata[15:0],  16'hABCD);
        check("rd_addr_hold", sd_addr,     26'h000100);
        check("rd_sel_done", sd_sel,       0);
        req = 3'b000;
        @(negedge clk);
        check("rd_ack_pulse", ack, 0);
        last_g = 1;

        // ---- burst read, port 2 ----
        set_port(2, 1'b0, 1'b1, 26'h0002000, 16'h0, 2'b00);
        sd_dout = 64'h1111_2222_3333_4444;
        req = 3'b100;
        @(negedge clk);
        check("br_burst", sd_burst, 1);
        check("br_rd",    sd_rd,    1);
        check("br_addr",  sd_addr,  26'h0002000);
        wait_ack(40, cyc);
        check("br_latency", cyc,   READ_LAT);
        check("br_ack",     ack,   3'b100);
        check("br_data",    rdata, 64'h1111_2222_3333_4444);
        req = 3'b000;
        @(negedge clk);
        last_g = 2;

        // ---- write, port 0; burst request must be ignored ----
        set_port(0, 1'b1, 1'b1, 26'h00003A5, 16'h5A5A, 2'b01);
        req = 3'b001;
        @(negedge clk);
        check("wr_wr",    sd_wr,    1);
        check("wr_rd",    sd_rd,    0);
        check("wr_din",   sd_din,   16'h5A5A);
        check("wr_bs",    sd_bs,    2'b01);
        check("wr_burst", sd_burst, 0);
        wait_ack(40, cyc);
        check("wr_latency", cyc,   READ_LAT);
        check("wr_ack",     ack,   3'b001);
        check("wr_err",     err,   0);
        check("wr_rdata",   rdata, 64'h1111_2222_3333_4444);
        req = 3'b000;
        @(negedge clk);
        last_g = 0;

        // ---- contention: all three ports held ----
        set_port(0, 1'b0, 1'b0, 26'h10, 16'h0, 2'b00);
        set_port(1, 1'b0, 1'b0, 26'h11, 16'h0, 2'b00);
        set_port(2, 1'b0, 1'b0, 26'h12, 16'h0, 2'b00);
        sd_dout = 64'hDEAD_BEEF_0000_1234;
        req = 3'b111;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            wait_ack(40, cyc);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            gi = (last_g + 1) % NPORTS;
`else
            gi = 0;
`endif
            exp_g = '0;
            exp_g[gi] = 1'b1;
            check("cont_grant", ack,     exp_g);
            check("cont_addr",  sd_addr, 26'h10 + gi);
            last_g = gi;
        end
        req = 3'b000;
        @(negedge clk);
        check("cont_rdata", rdata, 64'hDEAD_BEEF_0000_1234);

        // ---- timeout: ready never falls ----
        stuck = 1'b1;
        set_port(1, 1'b0, 1'b0, 26'h123, 16'h0, 2'b00);
        sd_dout = 64'hFFFF_FFFF_FFFF_FFFF;
        req = 3'b010;
        @(negedge clk);
        check("to_rd", sd_rd, 1);
        wait_ack(200, cyc);
        check("to_latency", cyc,    TIMEOUT);
        check("to_ack",     ack,    3'b010);
        check("to_err",     err,    1);
        check("to_rdata",   rdata,  64'hDEAD_BEEF_0000_1234);
        check("to_sel",     sd_sel, 0);
        req = 3'b000;
        @(negedge clk);
        check("to_err_pulse", err, 0);
        check("to_ack_pulse", ack, 0);
        @(negedge clk);
        check("to_idle_sel", sd_sel, 0);
        stuck = 1'b0;
        last_g = 1;

        // ---- init asserted while BUSY ----
        set_port(0, 1'b0, 1'b0, 26'h55, 16'h0, 2'b00);
        req = 3'b001;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("mr_busy_rd",  sd_rd,  0);
        check("mr_busy_sel", sd_sel, 1);
        @(negedge clk);
        init = 1'b1;
        req  = 3'b000;
        @(negedge clk);
        check("mr_ack",   ack,     0);
        check("mr_err",   err,     0);
        check("mr_sel",   sd_sel,  0);
        check("mr_rd",    sd_rd,   0);
        check("mr_addr",  sd_addr, 0);
        check("mr_rdata", rdata,   0);
        init = 1'b0;
        ack_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack != '0) ack_seen++;
        end
        check("mr_no_ack", ack_seen, 0);

        // ---- fresh request after reset ----
        set_port(2, 1'b0, 1'b0, 26'h777, 16'h0, 2'b00);
        sd_dout = 64'h0000_0000_0000_7777;
        req = 3'b100;
        @(negedge clk);
        wait_ack(40, cyc);
        check("post_latency", cyc,   READ_LAT);
        check("post_ack",     ack,   3'b100);
        check("post_rdata",   rdata, 64'h0000_0000_0000_7777);
        req = 3'b000;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
